spi_mem_arb: RTL and testbench
==============================

# spi_mem_arb

Two-requester arbiter and sequencer for the 16×8 SPI register memory, `spi_mem`. Requester A is the SPI slave command decoder; requester B is the local host bus. The block grants at most one access per cycle and drives the memory's write/read/address/data_in port. It returns read data to the owning requester exactly one cycle after the grant, matching the memory's registered `data_out`.

## Interface

**Parameters**

- `MAX_BURST`, default 4: maximum number of consecutive locked beats one requester may hold while the other is requesting. Legal range is 1–15.

**Ports**

Clock and reset:

- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.

Requester A:

- `a_req` input 1: access request.
- `a_lock` input 1: request to keep the grant on the next beat.
- `a_we` input 1: 1 = write, 0 = read.
- `a_addr` input 4: word address.
- `a_wdata` input 8: write data.
- `a_gnt` output 1: grant, combinational. A transfer happens when `a_req && a_gnt`.
- `a_rvalid` output 1: read data valid, registered.
- `a_rdata` output 8: read data. Equals `mem_data_out` when `a_rvalid`, otherwise 0.

Requester B:

- `b_req`, `b_lock`, `b_we`, `b_addr`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: identical to requester A.

Memory side:

- `mem_write` output 1: memory write strobe.
- `mem_read` output 1: memory read strobe.
- `mem_address` output 4: memory address.
- `mem_data_in` output 8: memory write data.
- `mem_data_out` input 8: memory read data. Valid the cycle after `mem_read`, and 0 otherwise.

## Operation

**Arbitration state**

- `last` is the id of the most recently granted requester. It resets to B, so A wins the first contended cycle.
- `owner_lock` is a 1-bit flag.
- `burst_cnt` is a saturating counter of width `$clog2(MAX_BURST+1)`.

**Grant decision (combinational, every cycle)**

1. If `owner_lock` is set, `last` is still requesting, and either `burst_cnt < MAX_BURST` or the other requester is idle: grant `last`.
2. Otherwise, if exactly one requester is requesting: grant it.
3. Otherwise, if both are requesting: grant the one that is not `last`.
4. Otherwise: no grant.

**Memory command (combinational from the granted request)**

- `mem_write = gnt & we`.
- `mem_read = gnt & ~we`.
- `mem_address` and `mem_data_in` take the granted requester's fields.
- All memory outputs are 0 when there is no grant.

**Registered update on a transfer**

- `last` ← granted id.
- `owner_lock` ← granted requester's lock bit.
- `burst_cnt` ← `burst_cnt + 1` (saturating) if the same id was granted last cycle under lock; otherwise 1.
- On a cycle with no transfer, `owner_lock` and `burst_cnt` clear to 0.

**Read return**

- A 2-bit tag register `{valid, id}` captures each read grant.
- The next cycle, the tagged requester's `rvalid` is 1 and its `rdata` = `mem_data_out`.
- Writes produce no response.

**Boundary conditions**

- Read-after-write to the same address on back-to-back cycles returns the new data. The write commits at the earlier edge.
- Lock held with the other requester idle: the owner keeps the grant indefinitely; `burst_cnt` saturates at `MAX_BURST`.
- Lock held with the other requester waiting: the switch happens after exactly `MAX_BURST` owner beats.
- The owner drops `req` while locked: the lock is released immediately.
- Reset mid-burst or with a read in flight:
  - `rvalid` is 0 the cycle after `rst`; the in-flight read response is discarded.
  - `last` = B, and `owner_lock`/`burst_cnt` = 0.
  - The memory's own reset is independent of this block.
- `a_gnt`/`b_gnt` are never both 1.
- A requester may change its request fields only after a transfer; the arbiter does not latch unaccepted requests.

## Timing

**Reset values**

- `a_gnt`, `b_gnt`, all `mem_*` outputs, `a_rvalid`, `b_rvalid`, `a_rdata`, `b_rdata` are all 0 while `rst` is asserted.
- Grants are forced low during `rst`.

**Cycle sequence for a read granted in cycle N**

- Cycle N: `mem_read` = 1.
- Edge ending N: the memory registers the data.
- Cycle N+1: `rvalid` = 1, with `rdata` valid.

**Throughput and latency**

- One access per cycle, fully pipelined; reads may be back-to-back.
- Write latency: the data is visible in memory after the edge ending cycle N.
- Arbitration latency is zero: `gnt` is asserted in the same cycle as `req`.

## Structure

- Package `spi_mem_pkg` holds:
  - `ADDR_W` = 4 and `DATA_W` = 8;
  - the `req_id_t` enum, with `REQ_A` = 0 and `REQ_B` = 1;
  - a packed struct `mem_req_t` `{we, addr, wdata}`.
- Sub-module `spi_mem_rr_pick` is the purely combinational 2-way round-robin/lock pick. Its inputs are `req[1:0]`, `last`, `owner_lock`, and `burst_at_max`; its output is one-hot `gnt[1:0]`.
- The top level `spi_mem_arb` holds the state registers, the response tag, and the muxes.

## Test plan

1. **Single write then read.** Reset, then A writes addr 3 = 0x5A. Next cycle A reads addr 3 → `mem_write` pulse with addr 3/0x5A; one cycle after the read grant, `a_rvalid` = 1 and `a_rdata` = 0x5A; `b_rvalid` stays 0.
2. **Contention round-robin.** A and B both hold `req` reading addr 0 and addr 1 for 4 cycles, no lock → grants alternate A, B, A, B starting with A; `rvalid` alternates one cycle later.
3. **Locked burst limit.** `MAX_BURST` = 4; A locks and reads addr 0–5 continuously while B requests → A is granted 4 beats, B 1 beat, then A resumes.
4. **Lock with idle peer.** A locks for 10 beats and B is idle → A is granted all 10 beats and `burst_cnt` saturates at 4.
5. **Reset mid-read.** B's read of addr 7 is granted in cycle N and `rst` is asserted in cycle N+1 → `b_rvalid` = 0 in N+1 and N+2; after release, A wins the first contended cycle.
6. **Back-to-back write then read.** B writes addr 15 = 0xC3, then immediately reads it on the next cycle → `b_rdata` = 0xC3; `a_gnt` stays 0 throughout.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// Shared types for the spi_mem arbiter slice.
// Requester ids and the per-requester memory command bundle.
package spi_mem_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/spi_mem_rr_pick.sv
// Combinational 2-way round-robin pick with a bounded lock hold.
// Produces a one-hot (or zero) grant vector.
module spi_mem_rr_pick
  import spi_mem_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  input  logic       owner_lock,
  input  logic       burst_at_max,
  output logic [1:0] gnt
);

  logic [1:0] w_last_oh;
  logic       w_own_req;
  logic       w_oth_req;

  assign w_last_oh = (last == REQ_A) ? 2'b01 : 2'b10;
  assign w_own_req = |(req & w_last_oh);
  assign w_oth_req = |(req & ~w_last_oh);

  // A locked owner keeps the bus until its hold budget runs out
  // against a waiting peer.
  always_comb begin
    gnt = 2'b00;
    if (owner_lock && w_own_req &&
        (!burst_at_max || !w_oth_req)) begin
      gnt = w_last_oh;
    end else if (req == 2'b01 || req == 2'b10) begin
      gnt = req;
    end else if (req == 2'b11) begin
      gnt = ~w_last_oh;
    end
  end

endmodule

// File: rtl/spi_mem_arb.sv
// Two-requester arbiter/sequencer for the 16x8 SPI register memory.
// Grants one access per cycle and routes read data back one cycle later.
module spi_mem_arb
  import spi_mem_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_lock,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_lock,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  req_id_t          r_last;
  logic             r_lock;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tag_v;
  req_id_t          r_tag_id;

  logic [1:0] w_pick;
  logic [1:0] w_gnt;
  logic       w_xfer;
  req_id_t    w_id;
  logic       w_sel_lock;
  mem_req_t   w_a;
  mem_req_t   w_b;
  mem_req_t   w_sel;

  assign w_a = '{we: a_we, addr: a_addr, wdata: a_wdata};
  assign w_b = '{we: b_we, addr: b_addr, wdata: b_wdata};

  spi_mem_rr_pick u_pick (
    .req          ({b_req, a_req}),
    .last         (r_last),
    .owner_lock   (r_lock),
    .burst_at_max (r_cnt >= MAX_CNT),
    .gnt          (w_pick)
  );

  assign w_gnt  = rst ? 2'b00 : w_pick;
  assign w_xfer = |w_gnt;
  assign w_id   = w_gnt[1] ? REQ_B : REQ_A;

  assign a_gnt = w_gnt[0];
  assign b_gnt = w_gnt[1];

  always_comb begin
    w_sel      = '0;
    w_sel_lock = 1'b0;
    if (w_gnt[0]) begin
      w_sel      = w_a;
      w_sel_lock = a_lock;
    end else if (w_gnt[1]) begin
      w_sel      = w_b;
      w_sel_lock = b_lock;
    end
  end

  assign mem_write   = w_xfer & w_sel.we;
  assign mem_read    = w_xfer & ~w_sel.we;
  assign mem_address = w_sel.addr;
  assign mem_data_in = w_sel.wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last   <= REQ_B;
      r_lock   <= 1'b0;
      r_cnt    <= '0;
      r_tag_v  <= 1'b0;
      r_tag_id <= REQ_A;
    end else begin
      r_tag_v  <= w_xfer & ~w_sel.we;
      r_tag_id <= w_id;
      if (w_xfer) begin
        r_last <= w_id;
        r_lock <= w_sel_lock;
        // Count continues only across a locked beat by the same owner.
        if (r_lock && (w_id == r_last)) begin
          if (r_cnt < MAX_CNT) r_cnt <= r_cnt + CNT_W'(1);
        end else begin
          r_cnt <= CNT_W'(1);
        end
      end else begin
        r_lock <= 1'b0;
        r_cnt  <= '0;
      end
    end
  end

  assign a_rvalid = r_tag_v & ~rst & (r_tag_id == REQ_A);
  assign b_rvalid = r_tag_v & ~rst & (r_tag_id == REQ_B);
  assign a_rdata  = a_rvalid ? mem_data_out : '0;
  assign b_rdata  = b_rvalid ? mem_data_out : '0;

endmodule

// File: tb/tb_spi_mem_arb.sv
// Directed testbench for spi_mem_arb with a behavioural 16x8 memory.
// Each task drives one scenario and checks against hand-computed values.
module tb_spi_mem_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req = 0, a_lock = 0, a_we = 0;
  logic [3:0] a_addr = 0;
  logic [7:0] a_wdata = 0;
  logic       b_req = 0, b_lock = 0, b_we = 0;
  logic [3:0] b_addr = 0;
  logic [7:0] b_wdata = 0;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       mem_write, mem_read;
  logic [3:0] mem_address;
  logic [7:0] mem_data_in;
  logic [7:0] mem_data_out;

  int errs = 0;
  int checks = 0;

  logic [7:0] mem [16];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_data_in;
    mem_data_out <= mem_read ? mem[mem_address] : 8'h00;
  end

  spi_mem_arb #(.MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_lock(a_lock), .a_we(a_we),
    .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_lock(b_lock), .b_we(b_we),
    .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic r, input logic l, input logic w,
                       input logic [3:0] ad, input logic [7:0] d);
    a_req = r; a_lock = l; a_we = w; a_addr = ad; a_wdata = d;
  endtask

  task automatic set_b(input logic r, input logic l, input logic w,
                       input logic [3:0] ad, input logic [7:0] d);
    b_req = r; b_lock = l; b_we = w; b_addr = ad; b_wdata = d;
  endtask

  task automatic idle;
    set_a(0, 0, 0, 4'h0, 8'h00);
    set_b(0, 0, 0, 4'h0, 8'h00);
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_a(1, 0, 0, 4'h3, 8'h00);
    set_b(1, 0, 1, 4'h5, 8'h77);
    @(negedge clk);
    checks++;
    if ({a_gnt, b_gnt} !== 2'b00) begin
      errs++; $display("FAIL rst_gnt got=%b exp=00", {a_gnt, b_gnt});
    end
    checks++;
    if ({mem_write, mem_read, mem_address, mem_data_in} !== 14'h0) begin
      errs++; $display("FAIL rst_mem got=%h exp=0",
                       {mem_write, mem_read, mem_address, mem_data_in});
    end
    checks++;
    if ({a_rvalid, b_rvalid, a_rdata, b_rdata} !== 18'h0) begin
      errs++; $display("FAIL rst_resp got=%h exp=0",
                       {a_rvalid, b_rvalid, a_rdata, b_rdata});
    end
    tick();
    rst = 1'b0;
    set_b(1, 0, 0, 4'h5, 8'h00);
    @(negedge clk);
    checks++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      errs++; $display("FAIL rst_first_win got=%b exp=10", {a_gnt, b_gnt});
    end
    tick();
    idle();
  endtask

  task automatic test_write_read;
    do_reset();
    set_a(1, 0, 1, 4'h3, 8'h5A);
    @(negedge clk);
    checks++;
    if ({a_gnt, mem_write, mem_read, mem_address, mem_data_in} !==
        {1'b1, 1'b1, 1'b0, 4'h3, 8'h5A}) begin
      errs++; $display("FAIL wr_cmd got=%h exp=%h",
        {a_gnt, mem_write, mem_read, mem_address, mem_data_in},
        {1'b1, 1'b1, 1'b0, 4'h3, 8'h5A});
    end
    tick();
    set_a(1, 0, 0, 4'h3, 8'h00);
    @(negedge clk);
    checks++;
    if ({a_gnt, mem_write, mem_read, a_rvalid} !== 4'b1010) begin
      errs++; $display("FAIL rd_cmd got=%b exp=1010",
                       {a_gnt, mem_write, mem_read, a_rvalid});
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({a_rvalid, a_rdata} !== {1'b1, 8'h5A}) begin
      errs++; $display("FAIL rd_data got=%h exp=15a", {a_rvalid, a_rdata});
    end
    checks++;
    if (b_rvalid !== 1'b0) begin
      errs++; $display("FAIL rd_b_quiet got=%b exp=0", b_rvalid);
    end
    tick();
  endtask

  task automatic test_round_robin;
    logic ea, er;
    do_reset();
    set_a(1, 0, 1, 4'h0, 8'h11);
    tick();
    set_a(0, 0, 0, 4'h0, 8'h00);
    set_b(1, 0, 1, 4'h1, 8'h22);
    tick();
    do_reset();
    set_a(1, 0, 0, 4'h0, 8'h00);
    set_b(1, 0, 0, 4'h1, 8'h00);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) idle();
      @(negedge clk);
      if (i < 4) begin
        ea = (i % 2 == 0);
        checks++;
        if ({a_gnt, b_gnt, mem_address} !== {ea, ~ea, (ea ? 4'h0 : 4'h1)}) begin
          errs++; $display("FAIL rr_gnt%0d got=%h exp=%h", i,
            {a_gnt, b_gnt, mem_address}, {ea, ~ea, (ea ? 4'h0 : 4'h1)});
        end
      end
      if (i > 0) begin
        er = ((i - 1) % 2 == 0);
        checks++;
        if ({a_rvalid, b_rvalid, a_rdata, b_rdata} !==
            {er, ~er, (er ? 8'h11 : 8'h00), (er ? 8'h00 : 8'h22)}) begin
          errs++; $display("FAIL rr_resp%0d got=%h exp=%h", i,
            {a_rvalid, b_rvalid, a_rdata, b_rdata},
            {er, ~er, (er ? 8'h11 : 8'h00), (er ? 8'h00 : 8'h22)});
        end
      end
      tick();
    end
  endtask

  task automatic test_burst_limit;
    logic eb, g;
    logic [3:0] k;
    do_reset();
    k = 4'h0;
    set_b(1, 0, 0, 4'h2, 8'h00);
    set_a(1, 1, 0, k, 8'h00);
    for (int c = 0; c < 8; c++) begin
      eb = (c == 4);
      @(negedge clk);
      g = a_gnt;
      checks++;
      if ({a_gnt, b_gnt, mem_address} !== {~eb, eb, (eb ? 4'h2 : k)}) begin
        errs++; $display("FAIL burst_gnt%0d got=%h exp=%h", c,
          {a_gnt, b_gnt, mem_address}, {~eb, eb, (eb ? 4'h2 : k)});
      end
      tick();
      if (g) begin
        k = (k == 4'h5) ? 4'h0 : k + 4'h1;
        set_a(1, 1, 0, k, 8'h00);
      end
    end
    idle();
  endtask

  task automatic test_lock_idle;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      set_a(1, 1, 0, 4'(c), 8'h00);
      @(negedge clk);
      checks++;
      if ({a_gnt, b_gnt} !== 2'b10) begin
        errs++; $display("FAIL lock_idle%0d got=%b exp=10", c, {a_gnt, b_gnt});
      end
      tick();
    end
    set_b(1, 0, 0, 4'h9, 8'h00);
    @(negedge clk);
    checks++;
    if ({a_gnt, b_gnt} !== 2'b01) begin
      errs++; $display("FAIL lock_sat got=%b exp=01", {a_gnt, b_gnt});
    end
    tick();
    idle();
  endtask

  task automatic test_reset_mid_read;
    do_reset();
    set_b(1, 0, 0, 4'h7, 8'h00);
    @(negedge clk);
    checks++;
    if ({b_gnt, mem_read, mem_address} !== {1'b1, 1'b1, 4'h7}) begin
      errs++; $display("FAIL rmid_gnt got=%h exp=%h",
        {b_gnt, mem_read, mem_address}, {1'b1, 1'b1, 4'h7});
    end
    tick();
    rst = 1'b1;
    idle();
    @(negedge clk);
    checks++;
    if ({b_rvalid, b_rdata} !== 9'h0) begin
      errs++; $display("FAIL rmid_n1 got=%h exp=0", {b_rvalid, b_rdata});
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_rvalid, b_rvalid, b_rdata} !== 10'h0) begin
      errs++; $display("FAIL rmid_n2 got=%h exp=0",
                       {a_rvalid, b_rvalid, b_rdata});
    end
    tick();
    set_a(1, 0, 0, 4'h1, 8'h00);
    set_b(1, 0, 0, 4'h2, 8'h00);
    @(negedge clk);
    checks++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      errs++; $display("FAIL rmid_win got=%b exp=10", {a_gnt, b_gnt});
    end
    tick();
    idle();
  endtask

  task automatic test_back_to_back;
    do_reset();
    set_b(1, 0, 1, 4'hF, 8'hC3);
    @(negedge clk);
    checks++;
    if ({a_gnt, b_gnt, mem_write, mem_address, mem_data_in} !==
        {1'b0, 1'b1, 1'b1, 4'hF, 8'hC3}) begin
      errs++; $display("FAIL b2b_wr got=%h exp=%h",
        {a_gnt, b_gnt, mem_write, mem_address, mem_data_in},
        {1'b0, 1'b1, 1'b1, 4'hF, 8'hC3});
    end
    tick();
    set_b(1, 0, 0, 4'hF, 8'h00);
    @(negedge clk);
    checks++;
    if ({a_gnt, b_gnt, mem_read, mem_write} !== 4'b0110) begin
      errs++; $display("FAIL b2b_rd got=%b exp=0110",
                       {a_gnt, b_gnt, mem_read, mem_write});
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({a_gnt, a_rvalid, b_rvalid, b_rdata} !== {1'b0, 1'b0, 1'b1, 8'hC3}) begin
      errs++; $display("FAIL b2b_data got=%h exp=%h",
        {a_gnt, a_rvalid, b_rvalid, b_rdata}, {1'b0, 1'b0, 1'b1, 8'hC3});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_burst_limit();
    test_lock_idle();
    test_reset_mid_read();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
